// File: rtl/imem_prog.sv
// Synchronous instruction memory for the RV32 fetch stage, cleared to NOP after reset
// and loaded over a little-endian, auto-incrementing valid/ready byte stream.
module imem_prog #(
    parameter int          DEPTH    = 256,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prog_en,
    input  logic        prog_valid,
    input  logic [7:0]  prog_byte,
    output logic        prog_ready,
    output logic        prog_done,
    output logic        prog_ovf,
    output logic        busy,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic        fetch_fault
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    // Byte handshake: a byte transfers on a rising edge where prog_valid && prog_ready.
    typedef enum logic [1:0] {S_CLEAR, S_RUN, S_LOAD} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [31:0]   shift_q, shift_d;
    logic          prog_done_q, prog_done_d;
    logic          prog_ovf_q, prog_ovf_d;
    logic          fetch_valid_q, fetch_valid_d;
    logic [31:0]   fetch_instr_q, fetch_instr_d;
    logic          fetch_fault_q, fetch_fault_d;

    logic [31:0]   mem [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    logic [AW-1:0] fetch_idx;
    logic          fetch_bad;

    assign fetch_idx = fetch_addr[AW+1:2];
    assign fetch_bad = (|fetch_addr[1:0]) || (|fetch_addr[31:AW+2]);

    always_comb begin
        state_d       = state_q;
        clr_ptr_d     = clr_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        byte_cnt_d    = byte_cnt_q;
        shift_d       = shift_q;
        prog_done_d   = 1'b0;
        prog_ovf_d    = prog_ovf_q;
        fetch_valid_d = 1'b0;
        fetch_instr_d = fetch_instr_q;
        fetch_fault_d = fetch_fault_q;
        mem_we        = 1'b0;
        mem_waddr     = clr_ptr_q;
        mem_wdata     = NOP_WORD;
        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_IDX) state_d = S_RUN;
            end
            S_RUN: begin
                if (fetch_req) begin
                    fetch_valid_d = 1'b1;
                    fetch_fault_d = fetch_bad;
                    fetch_instr_d = fetch_bad ? NOP_WORD : mem[fetch_idx];
                end
                if (prog_en) begin
                    state_d    = S_LOAD;
                    wr_ptr_d   = '0;
                    byte_cnt_d = '0;
                    prog_ovf_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (!prog_en) begin
                    // Any partial word and a byte arriving this cycle are dropped.
                    state_d     = S_RUN;
                    prog_done_d = 1'b1;
                end else if (prog_valid) begin
                    if (wr_ptr_q[AW]) begin
                        prog_ovf_d = 1'b1;
                    end else begin
                        shift_d    = {prog_byte, shift_q[31:8]};
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        if (byte_cnt_q == 2'd3) begin
                            mem_we    = 1'b1;
                            mem_waddr = wr_ptr_q[AW-1:0];
                            mem_wdata = {prog_byte, shift_q[31:8]};
                            wr_ptr_d  = wr_ptr_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_CLEAR;
            clr_ptr_q     <= '0;
            wr_ptr_q      <= '0;
            byte_cnt_q    <= '0;
            shift_q       <= '0;
            prog_done_q   <= 1'b0;
            prog_ovf_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= NOP_WORD;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            byte_cnt_q    <= byte_cnt_d;
            shift_q       <= shift_d;
            prog_done_q   <= prog_done_d;
            prog_ovf_q    <= prog_ovf_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_instr_q <= fetch_instr_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
    end

    assign prog_ready  = (state_q == S_LOAD);
    assign busy        = (state_q != S_RUN);
    assign prog_done   = prog_done_q;
    assign prog_ovf    = prog_ovf_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_instr = fetch_instr_q;
    assign fetch_fault = fetch_fault_q;

endmodule

// File: tb/tb_imem_prog.sv
// Bench for imem_prog at DEPTH=16: directed and randomized loads/fetches checked
// against a word-array reference model of the programmed image.
module tb_imem_prog;
    localparam int          DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_en = 1'b0;
    logic        prog_valid = 1'b0;
    logic [7:0]  prog_byte = 8'h00;
    logic        prog_ready, prog_done, prog_ovf, busy;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = 32'h0;
    logic        fetch_valid, fetch_fault;
    logic [31:0] fetch_instr;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [7:0]  load_bytes [$];

    imem_prog #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst(rst),
        .prog_en(prog_en), .prog_valid(prog_valid), .prog_byte(prog_byte),
        .prog_ready(prog_ready), .prog_done(prog_done), .prog_ovf(prog_ovf), .busy(busy),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic exp_fault(input logic [31:0] addr);
        return (addr % 4 != 0) || (addr >= 4 * DEPTH);
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] addr);
        if (exp_fault(addr)) return NOP;
        return model_mem[addr / 4];
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 2))
            0:       return 32'($urandom_range(0, DEPTH - 1) * 4);
            1:       return 32'($urandom_range(0, 4 * DEPTH + 7));
            default: return $urandom;
        endcase
    endfunction

    task automatic fetch_once(input logic [31:0] addr, output logic v,
                              output logic [31:0] ins, output logic f);
        fetch_req = 1'b1;
        fetch_addr = addr;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        v = fetch_valid; ins = fetch_instr; f = fetch_fault;
    endtask

    // Streams load_bytes with random gaps; optionally ends the load and updates the model.
    task automatic run_load(input bit finish);
        int n;
        n = load_bytes.size();
        prog_en = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (prog_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_entry ready=%b busy=%b want 1 1", prog_ready, busy);
        end
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            prog_valid = 1'b1;
            prog_byte = load_bytes[i];
            @(posedge clk); #1;
            prog_valid = 1'b0;
            checks++;
            if (prog_ovf !== (i + 1 > 4 * DEPTH) || prog_ready !== 1'b1) begin
                errors++;
                $display("FAIL load_byte%0d ovf=%b ready=%b want ovf=%b ready=1",
                         i + 1, prog_ovf, prog_ready, (i + 1 > 4 * DEPTH));
            end
        end
        if (finish) begin
            prog_en = 1'b0;
            prog_valid = 1'b1;
            prog_byte = 8'($urandom);
            @(posedge clk); #1;
            prog_valid = 1'b0;
            checks++;
            if (prog_done !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL load_done done=%b busy=%b want 1 0", prog_done, busy);
            end
            for (int w = 0; w < n / 4 && w < DEPTH; w++)
                model_mem[w] = {load_bytes[4*w+3], load_bytes[4*w+2],
                                load_bytes[4*w+1], load_bytes[4*w]};
            @(posedge clk); #1;
            checks++;
            if (prog_done !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse done=%b want 0", prog_done);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; prog_en = 1'b0; prog_valid = 1'b0; fetch_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || prog_ready !== 1'b0 || prog_done !== 1'b0 || prog_ovf !== 1'b0 ||
            fetch_valid !== 1'b0 || fetch_instr !== NOP || fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b rdy=%b done=%b ovf=%b fv=%b fi=%h ff=%b want 1 0 0 0 0 %h 0",
                     busy, prog_ready, prog_done, prog_ovf, fetch_valid, fetch_instr, fetch_fault, NOP);
        end
        for (int w = 0; w < DEPTH; w++) model_mem[w] = NOP;
        rst = 1'b0;
        fetch_req = 1'b1;
        fetch_addr = 32'h0;
        for (int k = 1; k <= DEPTH; k++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== (k < DEPTH) || fetch_valid !== 1'b0) begin
                errors++;
                $display("FAIL clear_cycle%0d busy=%b fv=%b want busy=%b fv=0",
                         k, busy, fetch_valid, (k < DEPTH));
            end
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_first_fetch();
        logic v, f; logic [31:0] ins;
        fetch_once(32'h0, v, ins, f);
        checks++;
        if (v !== 1'b1 || ins !== NOP || f !== 1'b0) begin
            errors++;
            $display("FAIL first_fetch v=%b instr=%h fault=%b want 1 %h 0", v, ins, f, NOP);
        end
    endtask

    task automatic test_load_program();
        logic v, f; logic [31:0] ins;
        logic [31:0] want [3];
        want = '{32'h00a00513, 32'h00b00593, 32'h00000013};
        load_bytes = '{8'h13, 8'h05, 8'ha0, 8'h00, 8'h93, 8'h05, 8'hb0, 8'h00};
        run_load(1'b1);
        for (int w = 0; w < 3; w++) begin
            fetch_once(32'(4 * w), v, ins, f);
            checks++;
            if (v !== 1'b1 || ins !== want[w] || ins !== exp_instr(32'(4 * w)) || f !== 1'b0) begin
                errors++;
                $display("FAIL prog_word%0d v=%b instr=%h fault=%b want 1 %h 0", w, v, ins, f, want[w]);
            end
        end
    endtask

    task automatic test_fault();
        logic v, f; logic [31:0] ins;
        logic [31:0] addrs [3];
        addrs = '{32'h2, 32'h40, 32'h3C};
        for (int i = 0; i < 3; i++) begin
            fetch_once(addrs[i], v, ins, f);
            checks++;
            if (v !== 1'b1 || f !== exp_fault(addrs[i]) || ins !== exp_instr(addrs[i])) begin
                errors++;
                $display("FAIL fault_addr%h v=%b instr=%h fault=%b want 1 %h %b",
                         addrs[i], v, ins, f, exp_instr(addrs[i]), exp_fault(addrs[i]));
            end
        end
    endtask

    task automatic test_partial();
        logic v, f; logic [31:0] ins;
        load_bytes = {};
        for (int i = 0; i < 6; i++) load_bytes.push_back(8'($urandom));
        run_load(1'b1);
        checks++;
        if (prog_ovf !== 1'b0) begin
            errors++;
            $display("FAIL partial_ovf ovf=%b want 0", prog_ovf);
        end
        for (int w = 0; w < 2; w++) begin
            fetch_once(32'(4 * w), v, ins, f);
            checks++;
            if (v !== 1'b1 || ins !== exp_instr(32'(4 * w)) || f !== 1'b0) begin
                errors++;
                $display("FAIL partial_word%0d instr=%h want %h", w, ins, exp_instr(32'(4 * w)));
            end
        end
    endtask

    task automatic test_random_load();
        logic v, f; logic [31:0] ins;
        load_bytes = {};
        repeat ($urandom_range(1, 40)) load_bytes.push_back(8'($urandom));
        run_load(1'b1);
        for (int w = 0; w < DEPTH; w++) begin
            fetch_once(32'(4 * w), v, ins, f);
            checks++;
            if (v !== 1'b1 || ins !== exp_instr(32'(4 * w)) || f !== 1'b0) begin
                errors++;
                $display("FAIL rand_word%0d instr=%h fault=%b want %h 0", w, ins, f, exp_instr(32'(4 * w)));
            end
        end
    endtask

    task automatic test_overflow();
        logic v, f; logic [31:0] ins;
        load_bytes = {};
        repeat (68) load_bytes.push_back(8'($urandom));
        run_load(1'b1);
        checks++;
        if (prog_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky ovf=%b want 1", prog_ovf);
        end
        for (int w = 0; w < DEPTH; w++) begin
            fetch_once(32'(4 * w), v, ins, f);
            checks++;
            if (v !== 1'b1 || ins !== exp_instr(32'(4 * w))) begin
                errors++;
                $display("FAIL ovf_word%0d instr=%h want %h", w, ins, exp_instr(32'(4 * w)));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, last;
        last = NOP;
        fetch_req = 1'b1;
        for (int i = 0; i < 24; i++) begin
            a = rand_addr();
            fetch_addr = a;
            @(posedge clk); #1;
            last = exp_instr(a);
            checks++;
            if (fetch_valid !== 1'b1 || fetch_instr !== last || fetch_fault !== exp_fault(a)) begin
                errors++;
                $display("FAIL b2b_addr%h v=%b instr=%h fault=%b want 1 %h %b",
                         a, fetch_valid, fetch_instr, fetch_fault, last, exp_fault(a));
            end
        end
        fetch_req = 1'b0;
        fetch_addr = rand_addr();
        @(posedge clk); #1;
        checks++;
        if (fetch_valid !== 1'b0 || fetch_instr !== last) begin
            errors++;
            $display("FAIL hold v=%b instr=%h want 0 %h", fetch_valid, fetch_instr, last);
        end
    endtask

    task automatic test_fetch_in_load();
        prog_en = 1'b1;
        fetch_req = 1'b1;
        fetch_addr = 32'h4;
        @(posedge clk); #1;
        checks++;
        if (fetch_valid !== 1'b1 || fetch_instr !== exp_instr(32'h4)) begin
            errors++;
            $display("FAIL fetch_with_prog_en v=%b instr=%h want 1 %h", fetch_valid, fetch_instr, exp_instr(32'h4));
        end
        fetch_addr = 32'h8;
        @(posedge clk); #1;
        checks++;
        if (fetch_valid !== 1'b0 || fetch_instr !== exp_instr(32'h4)) begin
            errors++;
            $display("FAIL fetch_dropped_load v=%b instr=%h want 0 %h", fetch_valid, fetch_instr, exp_instr(32'h4));
        end
        fetch_req = 1'b0;
        prog_en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (prog_done !== 1'b1) begin
            errors++;
            $display("FAIL empty_load_done done=%b want 1", prog_done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_load();
        logic v, f; logic [31:0] ins;
        load_bytes = {};
        repeat (12) load_bytes.push_back(8'($urandom));
        run_load(1'b0);
        test_reset();
        fetch_once(32'h0, v, ins, f);
        checks++;
        if (v !== 1'b1 || ins !== NOP || f !== 1'b0) begin
            errors++;
            $display("FAIL reclear_word0 v=%b instr=%h fault=%b want 1 %h 0", v, ins, f, NOP);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_load_program();
        test_fault();
        test_partial();
        test_random_load();
        test_back_to_back();
        test_overflow();
        test_fetch_in_load();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
